// File: rtl/start_fsm_if.sv
// Handshake bundle between the convolution start sequencer and its controller.
// En comes from the controller; CLR and start go back out to the datapath.
interface start_fsm_if;
   logic En;
   logic CLR;
   logic start;

   modport master (output En, input CLR, input start);
   modport slave  (input En, output CLR, output start);
endinterface

// File: rtl/start_fsm.sv
// Start sequencer for the convolution engine: clear pulse, start pulse, then run,
// repeating every RESTART_PERIOD cycles while En stays high.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | disabled, outputs low, waiting for En
// S_CLEAR | CLR high for CLR_CYCLES cycles
// S_START | start high for START_CYCLES cycles
// S_RUN   | datapath computing; re-sequence after RESTART_PERIOD (0 = never)
module start_fsm #(
   parameter int unsigned CLR_CYCLES     = 1,
   parameter int unsigned START_CYCLES   = 1,
   parameter int unsigned RESTART_PERIOD = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   start_fsm_if.slave   io_seq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_RUN
   } state_t;

   localparam logic [15:0] CLR_TC   = 16'(CLR_CYCLES - 1);
   localparam logic [15:0] START_TC = 16'(START_CYCLES - 1);
   localparam logic [15:0] RUN_TC   = (RESTART_PERIOD == 0) ? 16'd0 : 16'(RESTART_PERIOD - 1);
   localparam logic        RUN_REPEATS = (RESTART_PERIOD != 0);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_next;
   logic        r_clr;
   logic        r_start;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt + 16'd1;
      if (!io_seq.En) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_next = S_CLEAR;
            S_CLEAR: if (r_cnt == CLR_TC)   w_next = S_START;
            S_START: if (r_cnt == START_TC) w_next = S_RUN;
            S_RUN:   if (RUN_REPEATS && (r_cnt == RUN_TC)) w_next = S_CLEAR;
            default: w_next = S_IDLE;
         endcase
      end
      // With no restart the RUN count is meaningless, so freeze it rather than let it wrap.
      if (w_next != r_state || w_next == S_IDLE) begin
         w_cnt_next = '0;
      end else if (w_next == S_RUN && !RUN_REPEATS) begin
         w_cnt_next = r_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_clr   <= 1'b0;
         r_start <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_clr   <= (w_next == S_CLEAR);
         r_start <= (w_next == S_START);
      end
   end

   assign io_seq.CLR   = r_clr;
   assign io_seq.start = r_start;

endmodule

// File: tb/tb_start_fsm.sv
// Bench for start_fsm: a default instance and a (3,2,0) instance share clock, reset and En,
// and are checked every cycle against a sequence-position reference model.
module tb_start_fsm;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   start_fsm_if if_a ();
   start_fsm_if if_b ();

   start_fsm u_dut_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_seq (if_a.slave)
   );

   start_fsm #(
      .CLR_CYCLES     (3),
      .START_CYCLES   (2),
      .RESTART_PERIOD (0)
   ) u_dut_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_seq (if_b.slave)
   );

   typedef struct {
      string      tag;
      logic [1:0] exp_a;
      logic [1:0] exp_b;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int pos_a   = -1;
   int pos_b   = -1;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got {CLR,start}=%b expected %b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Position within the clear/start/run sequence after the coming edge; -1 means idle.
   function automatic int nxt_pos(int pos, logic en, logic rn, int c, int s, int r);
      if (!rn || !en) return -1;
      if (pos < 0) return 0;
      if (r > 0 && pos + 1 == c + s + r) return 0;
      return pos + 1;
   endfunction

   function automatic logic [1:0] exp_out(int pos, int c, int s);
      if (pos < 0) return 2'b00;
      return {(pos < c), (pos >= c && pos < c + s)};
   endfunction

   task automatic step(input logic en, input string tag);
      sb_entry_t e;
      if_a.En = en;
      if_b.En = en;
      pos_a = nxt_pos(pos_a, en, rst_n, 1, 1, 16);
      pos_b = nxt_pos(pos_b, en, rst_n, 3, 2, 0);
      sb_q.push_back('{tag, exp_out(pos_a, 1, 1), exp_out(pos_b, 3, 2)});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({e.tag, "_a"}, {if_a.CLR, if_a.start}, e.exp_a);
      chk({e.tag, "_b"}, {if_b.CLR, if_b.start}, e.exp_b);
   endtask

   task automatic run(input logic en, input int n, input string tag);
      for (int i = 0; i < n; i++) step(en, tag);
   endtask

   initial begin
      rst_n   = 1'b0;
      if_a.En = 1'b1;
      if_b.En = 1'b1;
      #1;
      chk("rst0_a", {if_a.CLR, if_a.start}, 2'b00);
      chk("rst0_b", {if_b.CLR, if_b.start}, 2'b00);

      run(1'b1, 3, "rst_hold");
      rst_n = 1'b1;
      run(1'b1, 6, "rst_rel");
      run(1'b0, 2, "off");

      run(1'b1, 10, "dflt");
      run(1'b0, 2, "dflt_off");

      run(1'b1, 1, "ab_clr");
      run(1'b0, 1, "ab_clr_drop");
      run(1'b1, 2, "ab_st");
      run(1'b0, 1, "ab_st_drop");
      run(1'b1, 22, "ab_full");
      run(1'b0, 1, "ab_off");

      run(1'b1, 50, "long");
      run(1'b0, 2, "long_off");

      run(1'b1, 2, "arst_pre");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_a", {if_a.CLR, if_a.start}, 2'b00);
      chk("arst_b", {if_b.CLR, if_b.start}, 2'b00);
      pos_a = -1;
      pos_b = -1;
      run(1'b1, 1, "arst_hold");
      rst_n = 1'b1;
      run(1'b1, 8, "arst_rel");
      run(1'b0, 1, "end_off");

      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/start_fsm.md
Name: start_fsm

Overview:
- Start sequencer for the convolution engine.
- When enable is high, it issues a clear pulse (CLR) so the datapath clears its accumulators and counters, then a start pulse (start) that launches a computation.
- While enable stays high, the sequence repeats every RESTART_PERIOD cycles, one repeat per new tile/window.
- Dropping enable aborts at once and returns the block to idle.

Parameters:
- CLR_CYCLES, 1: number of cycles CLR is held high per sequence; legal range 1..255.
- START_CYCLES, 1: number of cycles start is held high per sequence; legal range 1..255.
- RESTART_PERIOD, 16: cycles spent in RUN before the clear/start sequence repeats. 0 means never repeat; stay in RUN until En falls. Legal range 0..65535.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- En  input  1  sequence enable, level-sensitive, synchronous to clk.
- CLR  output  1  registered clear pulse to the datapath.
- start  output  1  registered start pulse to the datapath.

Behaviour:
- Reset: while rst_n=0, state=IDLE, CLR=0, start=0, and all internal counters are 0. Reset takes effect immediately, including mid-sequence. The first sequence after release needs En sampled high.
- States: IDLE, CLEAR, START, RUN. Encoding is free. Outputs are registered and decoded from the next state, so they change on the same edge as the state.
- IDLE:
  - En=1 at a rising edge → CLEAR, CLR=1 from that edge.
  - En=0 → stay in IDLE, outputs 0.
- CLEAR:
  - CLR=1 and start=0 for exactly CLR_CYCLES cycles, then → START.
- START:
  - start=1 and CLR=0 for exactly START_CYCLES cycles, then → RUN.
- RUN:
  - CLR=0 and start=0.
  - If RESTART_PERIOD>0: after RESTART_PERIOD cycles in RUN → CLEAR, and the sequence repeats.
  - If RESTART_PERIOD=0: stay in RUN.
- Abort: En sampled 0 in any state → IDLE at that edge, with CLR=0 and start=0 from that edge. Counters are cleared.
- Re-enable: En returning to 1 always restarts from CLEAR, never resumes mid-sequence.
- Latency: En rising before edge k gives CLR high on cycles k..k+CLR_CYCLES-1. start is then high on the next START_CYCLES cycles.
- Exclusivity: CLR and start are never high in the same cycle.
- En held permanently high: the pattern repeats with period CLR_CYCLES+START_CYCLES+RESTART_PERIOD.
- Counters: width sized for the parameter maxima, saturating-free. Each counter reloads to 0 on every state change.
- No combinational path from En to outputs.

Test Plan:
- Reset: hold rst_n=0 with En=1 for 3 cycles → CLR=0, start=0 throughout. Release rst_n → CLR=1 on the first edge, then start=1 on the next edge (defaults).
- Defaults, En high from t=10 for 100 time units (10 cycles at 10-unit period):
  - CLR high on cycle 1 and start high on cycle 2.
  - Both low for 16 cycles.
  - Sequence does not repeat within the 10 cycles.
  - En=0 → both 0 on the next edge.
- Abort and restart: En low for 1 cycle during CLEAR or START → outputs 0 the next edge. En high again → CLR asserts again and a full sequence follows.
- Long enable, En=1 for 50 cycles (defaults) → CLR pulses at cycles 1, 19, 37 and start pulses at cycles 2, 20, 38. Period is 18; CLR and start never overlap.
- Parameters CLR_CYCLES=3, START_CYCLES=2, RESTART_PERIOD=0:
  - CLR high for exactly 3 cycles, start high for exactly 2 cycles.
  - Then both stay 0 indefinitely while En=1.
- Asynchronous reset mid-START: drive rst_n low between edges → start drops immediately without waiting for an edge, and the FSM is in IDLE on release.
